// File: rtl/ps2_rx_frame_ctrl.sv
// PS/2 receive frame controller: synchronizes and filters the device clock, assembles
// start/8 data/parity/stop frames and reports accepted codes, parity and framing faults.
module ps2_rx_frame_ctrl #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic            clk_s;
  logic            data_s;
  logic            filt_clk;
  logic            filt_prev;
  logic [FW-1:0]   filt_cnt;
  logic            fall;
  logic [2:0]      bitcnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [TW-1:0]   tcnt;
  logic            timeout;
  logic            parity_ok;

  // Handshake-free output contract: code_valid/parity_err/frame_err are single-cycle
  // registered pulses; scan_code is stable whenever code_valid is high and holds otherwise.

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // The filtered level only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall      = filt_prev & ~filt_clk;
  assign timeout   = (state != IDLE) && !fall && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign parity_ok = ^{shreg, par_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (fall || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (timeout) begin
        // Partial byte is dropped; the next falling edge must be a fresh start bit.
        state     <= IDLE;
        busy      <= 1'b0;
        bitcnt    <= '0;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!data_s) begin
              state  <= DATA;
              busy   <= 1'b1;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg[bitcnt] <= data_s;
            if (bitcnt == 3'd7) begin
              state <= PARITY;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          STOP: begin
            state  <= IDLE;
            busy   <= 1'b0;
            bitcnt <= '0;
            // A bad stop bit outranks a parity fault: one flag per frame.
            if (!data_s) begin
              frame_err <= 1'b1;
            end else if (parity_ok) begin
              scan_code  <= shreg;
              code_valid <= 1'b1;
            end else begin
              parity_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  a_one_flag : assert property (@(posedge clk) disable iff (reset)
    $onehot0({code_valid, parity_err, frame_err}));

  a_busy_state : assert property (@(posedge clk) disable iff (reset)
    busy == (state != IDLE));

endmodule

// File: tb/tb_ps2_rx_frame_ctrl.sv
// Bench for ps2_rx_frame_ctrl: directed and random PS/2 frames against a frame-level
// reference model; result pulses are collected by a monitor and matched in order.
module tb_ps2_rx_frame_ctrl;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 5000;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Event encoding: {code_valid, parity_err, frame_err, scan_code}
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [7:0]  model_code;

  ps2_rx_frame_ctrl #(.FILTER_LEN(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .scan_code  (scan_code),
    .code_valid (code_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #(4_000_000);
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // monitor
  always @(negedge clk) begin
    if (!reset && (code_valid || parity_err || frame_err))
      obs_q.push_back({code_valid, parity_err, frame_err, scan_code});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // reference model: outcome of a complete frame from its bit values
  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop);
    if (!stop) begin
      exp_q.push_back({3'b001, model_code});
    end else if (($countones({d, p}) % 2) == 1) begin
      model_code = d;
      exp_q.push_back({3'b100, d});
    end else begin
      exp_q.push_back({3'b010, model_code});
    end
  endtask

  // driver tasks
  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(2 * HALF);
    ps2_clk = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    ps2_bit(1'b0);
    check("busy_in_frame", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(stop);
    ps2_data = 1'b1;
    model_frame(d, p, stop);
  endtask

  // scoreboard drain
  task automatic drain(input string tag);
    wait_cycles(200);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size()) check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       stop;

    reset      = 1'b1;
    ps2_clk    = 1'b1;
    ps2_data   = 1'b1;
    model_code = 8'h00;
    wait_cycles(5);
    check("rst_scan_code", 32'(scan_code), 32'h0);
    check("rst_flags", 32'({code_valid, parity_err, frame_err, busy}), 32'h0);
    reset = 1'b0;
    wait_cycles(10);

    send_frame(8'h1C, 1'b0, 1'b1);
    drain("t1_good");
    send_frame(8'hFF, 1'b0, 1'b1);
    drain("t2_parity");
    send_frame(8'h08, 1'b0, 1'b0);
    drain("t3_stop");

    // truncated frame, then silence beyond the timeout
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    wait_cycles(TIMEOUT - 300);
    check("t4_busy_before_timeout", 32'(busy), 32'd1);
    check("t4_no_early_flag", 32'(obs_q.size()), 32'd0);
    wait_cycles(800);
    exp_q.push_back({3'b001, model_code});
    drain("t4_timeout");
    send_frame(8'h2F, 1'b0, 1'b1);
    drain("t4_after");

    // reset in the middle of a frame
    ps2_bit(1'b0);
    for (int i = 0; i < 6; i++) ps2_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_scan_code", 32'(scan_code), 32'h0);
    check("t5_rst_flags", 32'({code_valid, parity_err, frame_err, busy}), 32'h0);
    wait_cycles(3);
    reset = 1'b0;
    model_code = 8'h00;
    drain("t5_rst");
    send_frame(8'hF0, 1'b1, 1'b1);
    drain("t5_after");

    // short low glitches on an idle clock with data low
    ps2_data = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ps2_clk = 1'b0;
      wait_cycles(2);
      ps2_clk = 1'b1;
      wait_cycles($urandom_range(6, 12));
      if (i % 5 == 0) check("t6_glitch_busy", 32'(busy), 32'd0);
    end
    ps2_data = 1'b1;
    drain("t6_glitch");

    // random back-to-back frames
    for (int i = 0; i < 14; i++) begin
      d    = 8'($urandom_range(0, 255));
      p    = (($countones(d) % 2) == 0);
      if ($urandom_range(0, 3) == 0) p = ~p;
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, p, stop);
    end
    drain("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
